crc_fsk4_framer: RTL



---
 rtl/crc_fsk4_pkg.sv | 56 +++++
 rtl/fsk4_sym_timer.sv | 45 ++++
 rtl/crc_fsk4_framer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/crc_fsk4_pkg.sv
// crc_fsk4_pkg
//   Shared types and helpers for the CRC / 4FSK framer.
//   - state_t     : framer FSM states
//   - crc_update  : CRC over one data word fed MSB-first, computed in one cycle
//   - tone_map    : dibit to 4FSK tone index, Gray or binary
package crc_fsk4_pkg;

    // Widest CRC or data word crc_update can handle. Callers widen their
    // operands to this width and pass the real widths as arguments, so one
    // function serves every parameterisation of the framer.
    localparam int CRC_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STALL,
        CRC
    } state_t;

    // Feeds the low data_w bits of 'data' MSB-first through a crc_w-bit
    // CRC register with generator 'poly' (implicit top bit omitted).
    // The loop runs over the fixed maximum width so it unrolls at
    // elaboration. Bits above data_w are skipped.
    function automatic logic [CRC_MAX_W-1:0] crc_update(
        input logic [CRC_MAX_W-1:0] crc,
        input logic [CRC_MAX_W-1:0] data,
        input logic [CRC_MAX_W-1:0] poly,
        input int                   crc_w,
        input int                   data_w
    );
        logic [CRC_MAX_W-1:0] c;
        logic [CRC_MAX_W-1:0] mask;
        logic                 fb;
        mask = ~({CRC_MAX_W{1'b1}} << crc_w);
        c    = crc & mask;
        for (int i = CRC_MAX_W - 1; i >= 0; i--) begin
            if (i < data_w) begin
                fb = c[crc_w-1] ^ data[i];
                c  = (c << 1) & mask;
                if (fb) begin
                    c = c ^ (poly & mask);
                end
            end
        end
        return c;
    endfunction

    // Gray: 00->0, 01->1, 11->2, 10->3. Binary: identity.
    function automatic logic [1:0] tone_map(
        input logic [1:0] dibit,
        input logic       gray
    );
        return gray ? {dibit[1], dibit[1] ^ dibit[0]} : dibit;
    endfunction

endpackage

// File: rtl/fsk4_sym_timer.sv
// fsk4_sym_timer
//   Symbol hold timer for the 4FSK framer.
//   Ports:
//     sys_clk   : clock
//     reset     : synchronous, active-high
//     run       : a symbol is being emitted this cycle
//     seg_end   : the current dibit is the last of its word / CRC; the
//                 dibit count restarts at the next wrap
//     wrap      : final hold cycle of the current symbol
//     dibit_cnt : index of the current dibit within its word / CRC
module fsk4_sym_timer #(
    parameter int SYM_CYCLES = 4,
    parameter int CNT_W      = 2
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             run,
    input  logic             seg_end,
    output logic             wrap,
    output logic [CNT_W-1:0] dibit_cnt
);

    localparam int HOLD_W = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;

    logic [HOLD_W-1:0] hold_cnt;

    assign wrap = run && (hold_cnt == HOLD_W'(SYM_CYCLES - 1));

    // NOTE: registers are updated with non-blocking assignments so every
    // always_ff samples the pre-edge values of the others.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            hold_cnt  <= '0;
            dibit_cnt <= '0;
        end else if (run) begin
            if (wrap) begin
                hold_cnt  <= '0;
                dibit_cnt <= seg_end ? '0 : dibit_cnt + 1'b1;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/crc_fsk4_framer.sv
// crc_fsk4_framer
//   Takes a frame of DATA_W-bit words over valid/ready, computes a CRC_W-bit
//   CRC across the frame (MSB-first), then serialises the data followed by
//   the CRC as dibits, each mapped to a 4FSK tone and held SYM_CYCLES clocks.
//   Ports:
//     sys_clk, reset      : clock, synchronous active-high reset
//     in_data/valid/last  : word input; in_last marks the final word
//     in_ready            : word accepted when in_valid && in_ready at an edge
//     sym_out, sym_valid  : tone index and its qualifier
//     sym_first           : first data symbol of a frame
//     sym_last            : last CRC symbol of a frame
//     crc_out             : CRC of the last completed frame
//     busy                : a frame is in progress
module crc_fsk4_framer
    import crc_fsk4_pkg::*;
#(
    parameter int               DATA_W     = 8,
    parameter int               CRC_W      = 8,
    parameter logic [CRC_W-1:0] CRC_POLY   = CRC_W'(8'h07),
    parameter logic [CRC_W-1:0] CRC_INIT   = CRC_W'(8'h00),
    parameter int               SYM_CYCLES = 4,
    parameter int               GRAY       = 1
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [1:0]        sym_out,
    output logic              sym_valid,
    output logic              sym_first,
    output logic              sym_last,
    output logic [CRC_W-1:0]  crc_out,
    output logic              busy
);

    // The shift register holds either a data word or the CRC, left-aligned
    // so the symbol always comes from its top two bits.
    localparam int SH_W        = (DATA_W > CRC_W) ? DATA_W : CRC_W;
    localparam int DATA_DIBITS = DATA_W / 2;
    localparam int CRC_DIBITS  = CRC_W / 2;
    localparam int MAX_DIBITS  = SH_W / 2;
    localparam int CNT_W       = (MAX_DIBITS > 1) ? $clog2(MAX_DIBITS) : 1;

    state_t            state;
    state_t            state_next;
    logic [SH_W-1:0]   shreg;
    logic [CRC_W-1:0]  crc;
    logic [CRC_W-1:0]  crc_base;
    logic [CRC_W-1:0]  crc_next;
    logic              cur_last;
    logic              first_flag;
    logic              run;
    logic              wrap;
    logic              seg_end;
    logic              last_dibit;
    logic [CNT_W-1:0]  dibit_cnt;
    logic              accept;
    logic              load_crc;
    logic              done;
    logic [1:0]        tone;

    fsk4_sym_timer #(
        .SYM_CYCLES (SYM_CYCLES),
        .CNT_W      (CNT_W)
    ) u_timer (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .run       (run),
        .seg_end   (seg_end),
        .wrap      (wrap),
        .dibit_cnt (dibit_cnt)
    );

    assign run        = (state == DATA) || (state == CRC);
    assign last_dibit = (state == CRC) ? (dibit_cnt == CNT_W'(CRC_DIBITS - 1))
                                       : (dibit_cnt == CNT_W'(DATA_DIBITS - 1));
    assign seg_end    = wrap && last_dibit;
    assign accept     = in_valid && in_ready;
    assign tone       = tone_map(shreg[SH_W-1 -: 2], GRAY != 0);

    // A new frame starts from CRC_INIT; later words extend the running CRC.
    assign crc_base = (state == IDLE) ? CRC_INIT : crc;
    assign crc_next = CRC_W'(crc_update(CRC_MAX_W'(crc_base), CRC_MAX_W'(in_data),
                                        CRC_MAX_W'(CRC_POLY), CRC_W, DATA_W));

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        state_next = state;
        in_ready   = 1'b0;
        load_crc   = 1'b0;
        done       = 1'b0;
        sym_valid  = 1'b0;
        sym_out    = 2'b00;
        sym_first  = 1'b0;
        sym_last   = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                sym_valid = 1'b1;
                sym_out   = tone;
                sym_first = first_flag;
                if (seg_end) begin
                    if (cur_last) begin
                        load_crc   = 1'b1;
                        state_next = CRC;
                    end else begin
                        // Opening the handshake on the final hold cycle lets
                        // the next word follow with no idle symbol.
                        in_ready   = 1'b1;
                        state_next = in_valid ? DATA : STALL;
                    end
                end
            end
            STALL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = DATA;
                end
            end
            CRC: begin
                sym_valid = 1'b1;
                sym_out   = tone;
                sym_last  = last_dibit;
                if (seg_end) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            shreg      <= '0;
            crc        <= CRC_INIT;
            crc_out    <= '0;
            cur_last   <= 1'b0;
            first_flag <= 1'b0;
        end else begin
            if (accept) begin
                shreg    <= SH_W'(in_data) << (SH_W - DATA_W);
                crc      <= crc_next;
                cur_last <= in_last;
            end else if (load_crc) begin
                shreg <= SH_W'(crc) << (SH_W - CRC_W);
            end else if (wrap) begin
                shreg <= shreg << 2;
            end

            if (wrap) begin
                first_flag <= 1'b0;
            end
            if (accept && (state == IDLE)) begin
                first_flag <= 1'b1;
            end

            if (done) begin
                crc_out <= crc;
            end
        end
    end

endmodule
